pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline stage register that generalises the fixed per-signal stage latches (EX/MEM and similar) into one reusable block. It carries an opaque packed payload of `DATA_W` bits from an upstream stage to a downstream stage under valid/ready flow control. An optional skid entry keeps `in_ready` registered. The block also supports synchronous flush, optional payload clearing, and a saturating back-pressure counter for stall profiling.

## Interface

Parameters
- `DATA_W`, 32: payload width in bits; must be ≥ 1.
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with `in_ready = ~out_valid | out_ready`.
- `CLEAR_ON_FLUSH`, 1: 1 = flush also zeroes stored payloads; 0 = only valid bits are cleared.
- `CNT_W`, 16: width of the stall counter.

Ports
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flush` in 1: synchronous kill of all held and incoming entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: block can accept this cycle.
- `in_data` in `DATA_W`: upstream payload.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: downstream accepts the head entry.
- `out_data` out `DATA_W`: head payload.
- `stall_cnt` out `CNT_W`: cycles with `out_valid & ~out_ready`; saturates at all-ones.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.

## Operation

- Accept when `in_valid & in_ready`. Drain when `out_valid & out_ready`.
- State (SKID=1): EMPTY (no entries), ONE (main entry valid), FULL (main and skid entries valid). `in_ready = (state != FULL)`, taken from a register.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept without drain → FULL; the new entry goes to skid.
  - ONE + accept with drain → ONE; main is replaced by the new entry.
  - ONE + drain only → EMPTY.
  - FULL + drain → ONE; skid moves to main. Accept is impossible in FULL.
- SKID=0 uses only EMPTY and ONE. Accept with drain in the same cycle replaces the entry.
- Ordering is strict FIFO. No entry is ever duplicated or dropped except by flush.
- Flush has highest priority:
  - Next state is EMPTY and the incoming entry is discarded.
  - If CLEAR_ON_FLUSH=1, main and skid payloads go to 0.
  - `in_ready` is 1 in the cycle after a flush.
- `stall_cnt` increments by 1 each cycle where `out_valid & ~out_ready`, and holds at 2^CNT_W−1.
- `cnt_clr` wins over increment. Flush does not clear the counter.
- Reset (async, `rst_n` = 0):
  - State = EMPTY, `out_valid` = 0, `out_data` = 0, skid payload = 0, `stall_cnt` = 0.
  - `in_ready` = 0 while `rst_n` is low, and 1 from the first edge after release.
  - Reset asserted mid-transfer discards all entries immediately.

## Timing

- Latency is 1 cycle: data accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N.
- Throughput is 1 entry/cycle under continuous `out_ready` = 1, in both SKID modes.
- SKID=1: `in_ready` has no combinational path from `out_ready`, and `out_*` come from registers.
- SKID=0: `in_ready` depends combinationally on `out_ready`. Integrators must not close a loop through it.
- `out_data` is don't-care while `out_valid` = 0, except it must read 0 after reset and after a flush with CLEAR_ON_FLUSH=1.
- Simultaneous `flush` and `cnt_clr`: both take effect.
- Simultaneous `flush` and a drain in the same cycle: the downstream consumed the entry. The flush still empties the block.

## Structure

- Shared package `pipe_pkg`:
  - `pipe_state_e` enum (EMPTY, ONE, FULL).
  - `PIPE_CNT_MAX` helper function.
- Sub-module `pipe_sat_counter` (params `CNT_W`; inputs `inc`, `clr`; output `cnt`). It is reused by other profiling blocks.
- State/datapath logic stays in `pipe_stage_reg`.
- The SKID=0 path is selected by a generate block in the same module.

## Test plan

- Reset release, DATA_W=32, SKID=1:
  - While `rst_n` is low: `out_valid` = 0, `out_data` = 0, `in_ready` = 0, `stall_cnt` = 0.
  - After the first edge: `in_ready` = 1.
- Streaming: push 0x1..0x8 back-to-back with `out_ready` = 1 → 0x1..0x8 appear in order, one per cycle, starting 1 cycle after the first accept, with no bubbles.
- Back-pressure:
  - Push 0xA, 0xB with `out_ready` = 0 → state FULL, `in_ready` = 0, `out_data` = 0xA, `stall_cnt` increments each cycle.
  - Raise `out_ready` → outputs 0xA then 0xB, and `in_ready` returns to 1 after the first drain.
- Flush while FULL with `in_valid` = 1 carrying 0xC → next cycle `out_valid` = 0, `out_data` = 0 (CLEAR_ON_FLUSH=1), 0xC never appears, `in_ready` = 1.
- Counter saturation: CNT_W=4 with `out_ready` held at 0 for 20 cycles → `stall_cnt` = 15. Then `cnt_clr` = 1 → 0.
- SKID=0 variant:
  - Simultaneous accept and drain every cycle gives full throughput.
  - Asynchronous reset asserted mid-stream clears `out_valid` before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and counter helpers for pipeline stage blocks
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_e;
    function automatic logic [63:0] PIPE_CNT_MAX(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating event counter with synchronous clear
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIPE_CNT_MAX(CNT_W));
    logic [CNT_W-1:0] cnt_d, cnt_q;
    always_comb cnt_d = clr ? '0 : (inc && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry, flush and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter bit          SKID           = 1'b1,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);
    pipe_state_e       state_d, state_q;
    logic [DATA_W-1:0] main_d, main_q, skid_d, skid_q;
    logic              ready_d, ready_q;
    logic              accept, drain;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    // ready_q doubles as the "out of reset" flag that holds in_ready low during reset
    generate
        if (SKID) begin : g_skid
            assign ready_d  = (state_d != FULL);
            assign in_ready = ready_q;
        end else begin : g_noskid
            assign ready_d  = 1'b1;
            assign in_ready = ready_q & (~out_valid | out_ready);
        end
    endgenerate
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
                ONE: if (accept && drain) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
                FULL: if (drain) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for a SKID=1 (CNT_W=4) and a SKID=0 instance
module tb_pipe_stage_reg;
    logic clk;
    int n_chk = 0;
    int n_fail = 0;
    logic        a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_stall_cnt;
    logic        b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_stall_cnt;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    pipe_stage_reg #(.DATA_W(32), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(a_rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall_cnt), .cnt_clr(a_cnt_clr)
    );
    pipe_stage_reg #(.DATA_W(32), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(b_rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall_cnt), .cnt_clr(b_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (a_rst_n === 1'b1 && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_out", {32'd0, a_out_data}, 64'hdead);
            else chk("a_out_data", {32'd0, a_out_data}, {32'd0, qa.pop_front()});
        end
        if (b_rst_n === 1'b1 && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_out", {32'd0, b_out_data}, 64'hdead);
            else chk("b_out_data", {32'd0, b_out_data}, {32'd0, qb.pop_front()});
        end
    end

    initial begin
        {a_flush, a_in_valid, a_out_ready, a_cnt_clr, a_in_data} = '0;
        {b_flush, b_in_valid, b_out_ready, b_cnt_clr, b_in_data} = '0;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_stall_cnt", a_stall_cnt, 0);
        chk("b_rst_in_ready", b_in_ready, 0);
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        step();
        chk("rel_in_ready", a_in_ready, 1);
        chk("b_rel_in_ready", b_in_ready, 1);
        // streaming with continuous out_ready
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = i;
            qa.push_back(i);
            step();
            chk("stream_valid", a_out_valid, 1);
            chk("stream_head", a_out_data, i);
            chk("stream_in_ready", a_in_ready, 1);
        end
        a_in_valid = 1'b0;
        step();
        chk("stream_idle", a_out_valid, 0);
        chk("stream_nostall", a_stall_cnt, 0);
        // back-pressure fills main then skid
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 32'hA;
        qa.push_back(32'hA);
        step();
        chk("bp_one_ready", a_in_ready, 1);
        chk("bp_cnt0", a_stall_cnt, 0);
        a_in_data = 32'hB;
        qa.push_back(32'hB);
        step();
        a_in_valid = 1'b0;
        chk("bp_full_ready", a_in_ready, 0);
        chk("bp_full_head", a_out_data, 32'hA);
        chk("bp_cnt1", a_stall_cnt, 1);
        step();
        chk("bp_cnt2", a_stall_cnt, 2);
        chk("bp_hold_head", a_out_data, 32'hA);
        a_out_ready = 1'b1;
        step();
        chk("bp_drain1_ready", a_in_ready, 1);
        chk("bp_drain1_head", a_out_data, 32'hB);
        chk("bp_cnt_hold", a_stall_cnt, 2);
        step();
        chk("bp_empty", a_out_valid, 0);
        // flush while FULL with an incoming entry
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 32'h11;
        step();
        a_in_data = 32'h22;
        step();
        chk("fl_full_ready", a_in_ready, 0);
        a_in_data = 32'hC;
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        chk("fl_out_valid", a_out_valid, 0);
        chk("fl_out_data", a_out_data, 0);
        chk("fl_in_ready", a_in_ready, 1);
        a_out_ready = 1'b1;
        repeat (3) step();
        chk("fl_still_empty", a_out_valid, 0);
        // counter saturation and clear
        a_cnt_clr = 1'b1;
        step();
        a_cnt_clr = 1'b0;
        chk("sat_clr0", a_stall_cnt, 0);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 32'h5;
        qa.push_back(32'h5);
        step();
        a_in_valid = 1'b0;
        repeat (20) step();
        chk("sat_cnt15", a_stall_cnt, 15);
        a_cnt_clr = 1'b1;
        step();
        a_cnt_clr = 1'b0;
        chk("sat_clr_wins", a_stall_cnt, 0);
        a_out_ready = 1'b1;
        step();
        chk("a_drained", qa.size(), 0);
        // SKID=0: accept and drain every cycle
        b_out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            b_in_valid = 1'b1;
            b_in_data = 32'h100 + i;
            qb.push_back(32'h100 + i);
            step();
            chk("b_stream_valid", b_out_valid, 1);
            chk("b_stream_head", b_out_data, 32'h100 + i);
            chk("b_stream_ready", b_in_ready, 1);
        end
        #2;
        b_rst_n = 1'b0;
        b_in_valid = 1'b0;
        #1;
        chk("b_async_valid", b_out_valid, 0);
        chk("b_async_ready", b_in_ready, 0);
        qb.delete();
        @(negedge clk);
        b_rst_n = 1'b1;
        step();
        chk("b_rerel_ready", b_in_ready, 1);
        chk("b_rerel_valid", b_out_valid, 0);
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        b_in_data = 32'h1AA;
        qb.push_back(32'h1AA);
        step();
        b_in_valid = 1'b0;
        chk("b_bp_ready", b_in_ready, 0);
        chk("b_bp_head", b_out_data, 32'h1AA);
        b_out_ready = 1'b1;
        #1;
        chk("b_comb_ready", b_in_ready, 1);
        step();
        chk("b_empty", b_out_valid, 0);
        chk("b_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
